// File: rtl/soc_reset_ctrl.sv
// ---------------------------------------------------------------------------
// soc_reset_ctrl
//
// Purpose: central reset sequencer for the SoC. Global reset sources (PLL lock
// loss, external keyboard-controller reset) hold every domain in reset. Once
// the sources clear, a minimum stretch is applied and the domains are then
// released one by one, SEQ_GAP cycles apart. Each domain can also be held in
// reset by software, with the same stretch applied after the request drops.
//
// Ports:
//   clk           system clock (clk_sys)
//   rst_n         asynchronous active-low block reset
//   pll_locked    asynchronous PLL lock, low acts as a global reset source
//   ext_reset_n   asynchronous active-low external global reset source
//   sw_reset_req  per-domain software reset request (level, synchronous)
//   cause_clr     one-cycle pulse clearing the sticky cause bits
//   domain_reset  registered active-high reset, one bit per domain
//   all_released  high once sequencing is done and no domain is in reset
//   cause         sticky {sw, ext, pll} reset-cause bits
//
// Build option: define SOC_RESET_CAUSE_EN to implement the sticky cause
// register. Without it, cause is tied to 3'b000 and cause_clr is ignored.
// ---------------------------------------------------------------------------
module soc_reset_ctrl #(
  parameter int NUM_DOMAINS    = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int SEQ_GAP        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   ext_reset_n,
  input  logic [NUM_DOMAINS-1:0] sw_reset_req,
  input  logic                   cause_clr,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_released,
  output logic [2:0]             cause
);

  // The stretch counter only needs to reach STRETCH_CYCLES-1; the software
  // hold counters are loaded with STRETCH_CYCLES itself and count down.
  localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam int SWW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW  = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;
  localparam int IW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [SCW-1:0] STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);
  localparam logic [SWW-1:0] SW_LOAD      = SWW'(STRETCH_CYCLES);
  localparam logic [GW-1:0]  GAP_LAST     = GW'((SEQ_GAP > 0) ? SEQ_GAP - 1 : 0);
  localparam logic [IW-1:0]  IDX_LAST     = IW'(NUM_DOMAINS - 1);
  localparam logic [IW-1:0]  IDX_FIRST    = IW'((NUM_DOMAINS > 1) ? 1 : 0);

  // With no gap, or a single domain, everything is released at the end of
  // the stretch and the sequencing state is skipped entirely.
  localparam bit RELEASE_ALL_AT_ONCE = (SEQ_GAP == 0) || (NUM_DOMAINS == 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STRETCH,
    S_SEQ,
    S_RUN
  } state_t;

  logic pll_meta, pll_s;
  logic ext_meta, ext_s;
  logic global_src;

  state_t                 state, state_n;
  logic [SCW-1:0]         stretch_cnt, stretch_n;
  logic [GW-1:0]          gap_cnt, gap_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NUM_DOMAINS-1:0] global_hold, global_hold_n;

  logic [SWW-1:0]         sw_cnt   [NUM_DOMAINS];
  logic [SWW-1:0]         sw_cnt_n [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] sw_hold_n;

  // Two-flop synchronisers for the asynchronous global sources. They reset
  // to 0 so both sources read as active until real samples arrive, which
  // keeps the FSM in S_HOLD for at least two cycles after rst_n release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_meta <= 1'b0;
      pll_s    <= 1'b0;
      ext_meta <= 1'b0;
      ext_s    <= 1'b0;
    end else begin
      pll_meta <= pll_locked;
      pll_s    <= pll_meta;
      ext_meta <= ext_reset_n;
      ext_s    <= ext_meta;
    end
  end

  assign global_src = ~pll_s | ~ext_s;

  // Global sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HOLD;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      global_hold <= '1;
    end else begin
      state       <= state_n;
      stretch_cnt <= stretch_n;
      gap_cnt     <= gap_n;
      idx         <= idx_n;
      global_hold <= global_hold_n;
    end
  end

  // Next-state logic. An active global source overrides every transition
  // and throws the sequence back to the start.
  always_comb begin
    state_n       = state;
    stretch_n     = stretch_cnt;
    gap_n         = gap_cnt;
    idx_n         = idx;
    global_hold_n = global_hold;

    if (global_src) begin
      state_n       = S_HOLD;
      stretch_n     = '0;
      gap_n         = '0;
      idx_n         = '0;
      global_hold_n = '1;
    end else begin
      case (state)
        S_HOLD: begin
          state_n       = S_STRETCH;
          stretch_n     = '0;
          global_hold_n = '1;
        end
        S_STRETCH: begin
          if (stretch_cnt == STRETCH_LAST) begin
            stretch_n = '0;
            if (RELEASE_ALL_AT_ONCE) begin
              global_hold_n = '0;
              state_n       = S_RUN;
            end else begin
              global_hold_n[0] = 1'b0;
              state_n          = S_SEQ;
              idx_n            = IDX_FIRST;
              gap_n            = '0;
            end
          end else begin
            stretch_n = stretch_cnt + SCW'(1);
          end
        end
        S_SEQ: begin
          if (gap_cnt == GAP_LAST) begin
            gap_n              = '0;
            global_hold_n[idx] = 1'b0;
            if (idx == IDX_LAST) begin
              state_n = S_RUN;
              idx_n   = '0;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else begin
            gap_n = gap_cnt + GW'(1);
          end
        end
        S_RUN: begin
          state_n = S_RUN;
        end
        default: begin
          state_n       = S_HOLD;
          global_hold_n = '1;
        end
      endcase
    end
  end

  // Software holds: the counter is reloaded for as long as the request is
  // high, so a request re-raised during the stretch restarts it. The hold
  // stays asserted until the counter has drained to zero.
  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      sw_hold_n[i] = sw_reset_req[i] | (sw_cnt[i] != '0);
      if (sw_reset_req[i]) begin
        sw_cnt_n[i] = SW_LOAD;
      end else if (sw_cnt[i] != '0) begin
        sw_cnt_n[i] = sw_cnt[i] - SWW'(1);
      end else begin
        sw_cnt_n[i] = '0;
      end
    end
  end

  // Software hold counters and the registered domain resets. The output is
  // built from next-cycle holds so a request shows up on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        sw_cnt[i] <= '0;
      end
      domain_reset <= '1;
    end else begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        sw_cnt[i] <= sw_cnt_n[i];
      end
      domain_reset <= global_hold_n | sw_hold_n;
    end
  end

  assign all_released = (state == S_RUN) && (domain_reset == '0);

`ifdef SOC_RESET_CAUSE_EN
  logic [NUM_DOMAINS-1:0] sw_req_q;
  logic [2:0]             cause_q;
  logic [2:0]             cause_set;

  assign cause_set = {|(sw_reset_req & ~sw_req_q), ~ext_s, ~pll_s};

  // Sticky cause register; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_req_q <= '0;
      cause_q  <= 3'b000;
    end else begin
      sw_req_q <= sw_reset_req;
      cause_q  <= (cause_clr ? 3'b000 : cause_q) | cause_set;
    end
  end

  assign cause = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr;
  assign cause            = 3'b000;
`endif

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_soc_reset_ctrl
//
// Purpose: self-checking bench for soc_reset_ctrl at its default parameters.
// A timing-level reference model predicts domain_reset, all_released and
// cause each cycle: domain i leaves global reset once the synchronised
// sources have been quiet for 1 + STRETCH + i*GAP consecutive edges, and a
// software hold lasts until STRETCH edges after the last sampled request.
// Directed steps cover power-up, glitches, software holds and async reset,
// followed by a randomised phase.
//
// Build option: SOC_RESET_CAUSE_EN selects the sticky-cause expectations.
// ---------------------------------------------------------------------------
module tb_soc_reset_ctrl;

  localparam int N   = 4;
  localparam int ST  = 16;
  localparam int GAP = 8;
  localparam int BIG = 1000000;

  logic         clk;
  logic         rst_n;
  logic         pll_locked;
  logic         ext_reset_n;
  logic [N-1:0] sw_reset_req;
  logic         cause_clr;
  logic [N-1:0] domain_reset;
  logic         all_released;
  logic [2:0]   cause;

  int checks;
  int fails;

  int         run;
  int         since [N];
  bit         pll_h0, pll_h1, ext_h0, ext_h1;
  logic [N-1:0] req_prev;
  logic [2:0] exp_cause;

  soc_reset_ctrl #(
    .NUM_DOMAINS   (N),
    .STRETCH_CYCLES(ST),
    .SEQ_GAP       (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .ext_reset_n (ext_reset_n),
    .sw_reset_req(sw_reset_req),
    .cause_clr   (cause_clr),
    .domain_reset(domain_reset),
    .all_released(all_released),
    .cause       (cause)
  );

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state after rst_n: both sources read active for two edges.
  task automatic modelReset();
    run       = 0;
    for (int i = 0; i < N; i++) since[i] = BIG;
    pll_h0    = 1'b1;
    pll_h1    = 1'b1;
    ext_h0    = 1'b1;
    ext_h1    = 1'b1;
    req_prev  = '0;
    exp_cause = 3'b000;
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic modelEdge();
    bit pll_seen;
    bit ext_seen;
    pll_seen = pll_h1;
    ext_seen = ext_h1;
    if (pll_seen || ext_seen) run = 0;
    else if (run < BIG) run++;
    pll_h1 = pll_h0;
    pll_h0 = !pll_locked;
    ext_h1 = ext_h0;
    ext_h0 = !ext_reset_n;
    for (int i = 0; i < N; i++) begin
      if (sw_reset_req[i]) since[i] = 0;
      else if (since[i] < BIG) since[i]++;
    end
`ifdef SOC_RESET_CAUSE_EN
    exp_cause = (cause_clr ? 3'b000 : exp_cause) |
                {|(sw_reset_req & ~req_prev), ext_seen, pll_seen};
`endif
    req_prev = sw_reset_req;
  endtask

  function automatic logic [N-1:0] expDomain();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) begin
      e[i] = (run < 1 + ST + i * GAP) || (since[i] <= ST);
    end
    return e;
  endfunction

  function automatic logic expAll();
    return (run >= 1 + ST + (N - 1) * GAP) && (expDomain() == '0);
  endfunction

  // Compare all outputs against the model.
  task automatic checkOutput(input string tag);
    logic [N-1:0] ed;
    logic         ea;
    ed = expDomain();
    ea = expAll();
    checks++;
    assert (domain_reset === ed) else begin
      fails++;
      $error("[TB] FAIL %s domain_reset got %b expected %b", tag, domain_reset, ed);
    end
    checks++;
    assert (all_released === ea) else begin
      fails++;
      $error("[TB] FAIL %s all_released got %b expected %b", tag, all_released, ea);
    end
    checks++;
    assert (cause === exp_cause) else begin
      fails++;
      $error("[TB] FAIL %s cause got %b expected %b", tag, cause, exp_cause);
    end
  endtask

  // Directed single-value check against a constant from the timeline.
  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic stepReset(input string tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic pll, input logic ext, input logic [N-1:0] sw,
                               input logic clr, input int cycles, input string tag);
    pll_locked   = pll;
    ext_reset_n  = ext;
    sw_reset_req = sw;
    cause_clr    = clr;
    for (int c = 0; c < cycles; c++) step(tag);
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    rst_n        = 1'b1;
    pll_locked   = 1'b1;
    ext_reset_n  = 1'b1;
    sw_reset_req = '0;
    cause_clr    = 1'b0;
    modelReset();

    // Reset state.
    #2 rst_n = 1'b0;
    #1 checkOutput("reset");
    stepReset("reset_hold");
    stepReset("reset_hold");
    rst_n = 1'b1;

    // Power-up: domain 0 falls at edge 19, all released at edge 43.
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 18, "powerup");
    checkValue("pwr_d0_held", 32'(domain_reset[0]), 32'd1);
    step("powerup");
    checkValue("pwr_d0_free", 32'(domain_reset[0]), 32'd0);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 23, "powerup");
    checkValue("pwr_all_low", 32'(all_released), 32'd0);
    step("powerup");
    checkValue("pwr_all_high", 32'(all_released), 32'd1);
    checkValue("pwr_dom_zero", 32'(domain_reset), 32'd0);

    // Clear the power-up cause bits.
    applyStimulus(1'b1, 1'b1, '0, 1'b1, 1, "clr");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 2, "clr");

    // PLL glitch during sequencing with domains 0 and 1 released.
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1, "glitch_a");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 30, "reseq");
    checkValue("seq_d01_free", 32'(domain_reset), 32'b1100);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1, "glitch_b");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 2, "glitch_b");
    checkValue("glitch_reassert", 32'(domain_reset), 32'b1111);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 45, "glitch_b");
    checkValue("glitch_rerun", 32'(all_released), 32'd1);

    // Software hold on domain 2 only.
    applyStimulus(1'b1, 1'b1, 4'b0100, 1'b0, 1, "sw2");
    checkValue("sw2_only", 32'(domain_reset), 32'b0100);
    applyStimulus(1'b1, 1'b1, 4'b0100, 1'b0, 4, "sw2");
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 16, "sw2_stretch");
    checkValue("sw2_stretch_end", 32'(domain_reset), 32'b0100);
    step("sw2_release");
    checkValue("sw2_released", 32'(domain_reset), 32'b0000);

    // Domain 1 request re-raised at stretch cycle 10.
    applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 3, "sw1");
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 10, "sw1");
    applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 2, "sw1_again");
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 16, "sw1_stretch");
    checkValue("sw1_restart", 32'(domain_reset[1]), 32'd1);
    step("sw1_release");
    checkValue("sw1_released", 32'(domain_reset[1]), 32'd0);

    // External reset with a clear in the same cycle as the cause set.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 2, "ext");
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1, "ext_clr");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 3, "ext");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 5, "ext_done");
    applyStimulus(1'b1, 1'b1, '0, 1'b1, 1, "clr_alone");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 45, "ext_rerun");

    // Async reset in the middle of sequencing.
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1, "pre_rst");
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 30, "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("async_rst_dom", 32'(domain_reset), 32'b1111);
    checkValue("async_rst_all", 32'(all_released), 32'd0);
    checkOutput("async_rst");
    stepReset("async_rst_hold");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 45, "after_rst");

    // Randomised phase: rare source glitches, toggling requests, clears.
    for (int c = 0; c < 800; c++) begin
      pll_locked  = ($urandom_range(0, 149) != 0);
      ext_reset_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 24) == 0) sw_reset_req[i] = ~sw_reset_req[i];
      end
      cause_clr = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
